// File: rtl/deit_stream_feeder_if.sv
// Bundles host writes, core strobes and feeder outputs for deit_stream_feeder.
// No latency of its own; it only carries wires.
// There is no backpressure. Host writes are qualified by host_buf_ready.
//
// Ports (as seen by the slave / feeder side):
//   host_wr_en, host_wr_sel, host_wr_addr, host_wr_data   host buffer write port
//   cfg_act_len, host_err_clr                            host configuration and control
//   ctrl_weight_load_en, ctrl_input_stream_en            core controller phase strobes
//   out_weight_vec, out_act_vec                          operands returned to the core
//   host_buf_ready, feeder_state, err_underrun, err_wr_busy   status back to the host
interface deit_stream_feeder_if #(
    parameter int ARRAY_ROW  = 12,
    parameter int ARRAY_COL  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 6
) ();
    logic                             host_wr_en;
    logic                             host_wr_sel;
    logic [AW-1:0]                    host_wr_addr;
    logic [ARRAY_COL*DATA_WIDTH-1:0]  host_wr_data;
    logic [AW:0]                      cfg_act_len;
    logic                             host_err_clr;
    logic                             ctrl_weight_load_en;
    logic                             ctrl_input_stream_en;
    logic [ARRAY_COL*DATA_WIDTH-1:0]  out_weight_vec;
    logic [ARRAY_ROW*DATA_WIDTH-1:0]  out_act_vec;
    logic                             host_buf_ready;
    logic [1:0]                       feeder_state;
    logic                             err_underrun;
    logic                             err_wr_busy;

    // Host/core side: drives the write port, config and strobes.
    modport master (
        output host_wr_en, host_wr_sel, host_wr_addr, host_wr_data,
        output cfg_act_len, host_err_clr,
        output ctrl_weight_load_en, ctrl_input_stream_en,
        input  out_weight_vec, out_act_vec,
        input  host_buf_ready, feeder_state, err_underrun, err_wr_busy
    );

    // Feeder side.
    modport slave (
        input  host_wr_en, host_wr_sel, host_wr_addr, host_wr_data,
        input  cfg_act_len, host_err_clr,
        input  ctrl_weight_load_en, ctrl_input_stream_en,
        output out_weight_vec, out_act_vec,
        output host_buf_ready, feeder_state, err_underrun, err_wr_busy
    );
endinterface

// File: rtl/deit_stream_feeder.sv
// Operand buffer: returns weight rows / activation vectors to the core on its phase strobes.
// Latency: 1 cycle registered; the strobe at cycle t gives entry k during cycle t+1+k.
// Backpressure: none to the core. Host writes are accepted only in IDLE and are dropped otherwise (err_wr_busy).
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus (slave)    host write port, cfg_act_len, host_err_clr, core strobes,
//                  out_weight_vec / out_act_vec, host_buf_ready, feeder_state,
//                  sticky err_underrun / err_wr_busy
module deit_stream_feeder #(
    parameter int ARRAY_ROW  = 12,
    parameter int ARRAY_COL  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ACT_DEPTH  = 64,
    parameter int AW         = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    deit_stream_feeder_if.slave  bus
);
    localparam int WW  = ARRAY_COL * DATA_WIDTH;
    localparam int AVW = ARRAY_ROW * DATA_WIDTH;
    // The weight pointer must be able to hold ARRAY_ROW itself, which is its saturated value.
    localparam int WPW = $clog2(ARRAY_ROW + 1);

    localparam logic [WPW-1:0] W_SAT     = WPW'(ARRAY_ROW);
    localparam logic [AW:0]    A_SAT     = (AW + 1)'(ACT_DEPTH);
    localparam logic [AW-1:0]  W_ADDR_LIM = AW'(ARRAY_ROW);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_W_LOAD   = 2'd1,
        ST_A_STREAM = 2'd2
    } state_t;

    state_t          state_q, state_d;

    // Operand storage. It is not reset; the host must fill an entry before it is streamed.
    logic [WW-1:0]   wbuf [ARRAY_ROW];
    logic [AVW-1:0]  abuf [ACT_DEPTH];

    logic [WPW-1:0]  w_ptr_q, w_ptr_d;
    logic [AW:0]     a_ptr_q, a_ptr_d;
    logic [WW-1:0]   w_vec_q, w_vec_d;
    logic [AVW-1:0]  a_vec_q, a_vec_d;
    logic            ready_q;
    logic            err_under_q, err_under_d;
    logic            err_busy_q, err_busy_d;

    logic            under_set;
    logic            busy_set;
    logic            wbuf_we;
    logic            abuf_we;
    logic            weight_go;
    logic            stream_req;
    logic [WPW-1:0]  w_wr_idx;

    assign weight_go  = bus.ctrl_weight_load_en;
    assign stream_req = bus.ctrl_input_stream_en;
    assign w_wr_idx   = bus.host_wr_addr[WPW-1:0];

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // Next state, datapath selects and host-write qualification
    //------------------------------------------------------------------
    always_comb begin
        state_d   = ST_IDLE;
        w_ptr_d   = '0;
        w_vec_d   = '0;
        a_ptr_d   = '0;
        a_vec_d   = '0;
        under_set = 1'b0;
        busy_set  = 1'b0;
        wbuf_we   = 1'b0;
        abuf_we   = 1'b0;

        // The weight strobe has priority over the activation strobe.
        if (weight_go) begin
            state_d = ST_W_LOAD;
        end else if (stream_req) begin
            state_d = ST_A_STREAM;
        end

        // Weight path. An over-long strobe is legal: it returns zeros and holds the pointer.
        if (weight_go) begin
            if (w_ptr_q < W_SAT) begin
                w_vec_d = wbuf[w_ptr_q];
                w_ptr_d = w_ptr_q + 1'b1;
            end else begin
                w_ptr_d = w_ptr_q;
            end
        end

        // Activation path.
        if (stream_req && weight_go) begin
            // Collision: the core wants both operands at once. Freeze the stream and flag it.
            a_ptr_d   = a_ptr_q;
            under_set = 1'b1;
        end else if (stream_req) begin
            if (a_ptr_q < bus.cfg_act_len) begin
                a_vec_d = abuf[a_ptr_q[AW-1:0]];
                a_ptr_d = a_ptr_q + 1'b1;
            end else begin
                // Reading past the valid data returns zeros. The pointer keeps counting
                // up to ACT_DEPTH so it can never wrap back into valid entries.
                under_set = 1'b1;
                a_ptr_d   = (a_ptr_q == A_SAT) ? a_ptr_q : a_ptr_q + 1'b1;
            end
        end

        // A host write is accepted only when the buffers are provably not being read,
        // both this cycle and last. This is why no write-to-read bypass is needed.
        if (bus.host_wr_en) begin
            if ((state_q == ST_IDLE) && !weight_go && !stream_req) begin
                if (bus.host_wr_sel) begin
                    abuf_we = 1'b1;
                end else if (bus.host_wr_addr < W_ADDR_LIM) begin
                    wbuf_we = 1'b1;
                end
            end else begin
                busy_set = 1'b1;
            end
        end

        // Sticky flags: a set in the same cycle as the clear wins.
        err_under_d = (err_under_q & ~bus.host_err_clr) | under_set;
        err_busy_d  = (err_busy_q  & ~bus.host_err_clr) | busy_set;
    end

    //------------------------------------------------------------------
    // Pointers, output registers and status
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            a_ptr_q     <= '0;
            w_vec_q     <= '0;
            a_vec_q     <= '0;
            ready_q     <= 1'b0;
            err_under_q <= 1'b0;
            err_busy_q  <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            a_ptr_q     <= a_ptr_d;
            w_vec_q     <= w_vec_d;
            a_vec_q     <= a_vec_d;
            // Registered from the next state, so it always equals (state == IDLE)
            // but still reads 0 while reset is held.
            ready_q     <= (state_d == ST_IDLE);
            err_under_q <= err_under_d;
            err_busy_q  <= err_busy_d;
        end
    end

    //------------------------------------------------------------------
    // Buffer storage (no reset)
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wbuf_we) begin
            wbuf[w_wr_idx] <= bus.host_wr_data;
        end
        if (abuf_we) begin
            abuf[bus.host_wr_addr] <= bus.host_wr_data[AVW-1:0];
        end
    end

    assign bus.out_weight_vec = w_vec_q;
    assign bus.out_act_vec    = a_vec_q;
    assign bus.host_buf_ready = ready_q;
    assign bus.feeder_state   = state_q;
    assign bus.err_underrun   = err_under_q;
    assign bus.err_wr_busy    = err_busy_q;

endmodule
